// File: rtl/mempipe_sched.sv
// mempipe_sched: mm0-stage arbiter for the memory pipe.
// Picks at most one of NREQ requesters per cycle (starving requesters first,
// then round-robin), and registers the winner into the mm1 stage.
module mempipe_sched #(
    parameter int NREQ          = 3,
    parameter int PKT_W         = 64,
    parameter int STARVE_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid_mm0,
    input  logic [NREQ*PKT_W-1:0] req_pkt_mm0,
    output logic [NREQ-1:0]       gnt_mm0,
    input  logic                  pipe_block_mm0,
    input  logic                  flush,
    output logic                  pipe_valid_mm1,
    output logic [PKT_W-1:0]      pipe_pkt_mm1,
    output logic [NREQ-1:0]       pipe_src_mm1,
    output logic [NREQ-1:0]       starve_mm0,
    output logic                  idle
);

    localparam int CNT_W = $clog2(STARVE_THRESH + 1);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(STARVE_THRESH);
    localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NREQ - 1);

    logic [PTR_W-1:0] rr_ptr;
    logic [CNT_W-1:0] starve_cnt [NREQ];
    logic [NREQ-1:0]  starving_req;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             stalled;
    logic [PKT_W-1:0] gnt_pkt;

    // Requester index k slots above the round-robin pointer, wrapping at NREQ.
    function automatic logic [PTR_W-1:0] rr_slot(input logic [PTR_W-1:0] ptr, input int k);
        int j;
        j = int'(ptr) + k;
        if (j >= NREQ) j -= NREQ;
        return PTR_W'(j);
    endfunction

    assign stalled = pipe_block_mm0 || flush;

    // Starving flag: counter has saturated at the threshold.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            starve_mm0[i] = (starve_cnt[i] == THRESH);
        end
    end

    // Grant selection: lowest-index starving requester, else first valid
    // requester at or above rr_ptr. Nothing is granted while stalled or in reset.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        gnt_any      = 1'b0;
        gnt_idx      = '0;
        gnt_mm0      = '0;
        starving_req = req_valid_mm0 & starve_mm0;
        if (!(reset || stalled)) begin
            if (|starving_req) begin
                gnt_any = 1'b1;
                // Descending scan: the last hit, i.e. the lowest index, wins.
                for (int i = NREQ - 1; i >= 0; i--) begin
                    if (starving_req[i]) gnt_idx = PTR_W'(i);
                end
            end else if (|req_valid_mm0) begin
                gnt_any = 1'b1;
                // Descending distance from rr_ptr: the nearest valid slot wins.
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req_valid_mm0[rr_slot(rr_ptr, k)]) gnt_idx = rr_slot(rr_ptr, k);
                end
            end
        end
        if (gnt_any) gnt_mm0[gnt_idx] = 1'b1;
    end

    assign gnt_pkt = req_pkt_mm0[gnt_idx*PKT_W +: PKT_W];

    // Round-robin pointer: moves just past the winner, holds when nothing granted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (reset) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Starvation counters: cleared when served or idle, frozen while the pipe
    // is stalled, otherwise count unserved cycles up to the threshold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                starve_cnt[i] <= '0;
            end else if (!req_valid_mm0[i] || gnt_mm0[i]) begin
                starve_cnt[i] <= '0;
            end else if (!stalled && starve_cnt[i] != THRESH) begin
                starve_cnt[i] <= starve_cnt[i] + 1'b1;
            end
        end
    end

    // mm1 stage: capture the winner; a flush empties the stage.
    always_ff @(posedge clk) begin
        // NOTE: the packet register is reset too so mm1 leaves reset in a
        // known state even though its contents only matter when valid.
        if (reset) begin
            pipe_valid_mm1 <= 1'b0;
            pipe_src_mm1   <= '0;
            pipe_pkt_mm1   <= '0;
        end else begin
            if (flush) begin
                pipe_valid_mm1 <= 1'b0;
                pipe_src_mm1   <= '0;
            end else begin
                pipe_valid_mm1 <= gnt_any;
                pipe_src_mm1   <= gnt_mm0;
            end
            if (gnt_any) pipe_pkt_mm1 <= gnt_pkt;
        end
    end

    assign idle = !(|req_valid_mm0) && !pipe_valid_mm1;

endmodule
